aclock_set_ctrl: RTL and testbench

//  Button-driven setting sequencer for the alarm clock core. Walks the user through

---
 rtl/aclock_pkg.sv | 32 +++
 rtl/aclock_btn_edge.sv | 22 ++
 rtl/aclock_set_ctrl.sv | 176 +++++++++++++++++
 tb/tb_aclock_set_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aclock_pkg.sv
// Shared constants for the alarm clock setting sequencer: state codes, digit limits,
// button bit positions and edit-field one-hot codes.
package aclock_pkg;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StEH1  = 3'd1;
  localparam logic [2:0] StEH0  = 3'd2;
  localparam logic [2:0] StEM1  = 3'd3;
  localparam logic [2:0] StEM0  = 3'd4;
  localparam logic [2:0] StLoad = 3'd5;

  localparam logic [1:0] H1Max    = 2'd2;
  localparam logic [3:0] H0Max    = 4'd9;
  localparam logic [3:0] H0MaxAt2 = 4'd3;
  localparam logic [3:0] M1Max    = 4'd5;
  localparam logic [3:0] M0Max    = 4'd9;

  localparam logic [3:0] FieldH1 = 4'b1000;
  localparam logic [3:0] FieldH0 = 4'b0100;
  localparam logic [3:0] FieldM1 = 4'b0010;
  localparam logic [3:0] FieldM0 = 4'b0001;

  localparam int unsigned BtnTime  = 3;
  localparam int unsigned BtnAlarm = 2;
  localparam int unsigned BtnNext  = 1;
  localparam int unsigned BtnInc   = 0;

  function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] max);
    return (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/aclock_btn_edge.sv
// Rising-edge detector for the four panel buttons; pulse is high in the first cycle a
// button is seen high after having been low on the previous clock.
module aclock_btn_edge (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_i,
  output logic [3:0] rise_o
);

  logic [3:0] prev_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= btn_i;
    end
  end

  assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/aclock_set_ctrl.sv
// Button-driven HH:MM setting sequencer: edits time or alarm digit by digit, then holds
// LD_time/LD_alarm long enough for the 1 s update clock of the core to sample them.
module aclock_set_ctrl
  import aclock_pkg::*;
#(
  parameter int unsigned LD_HOLD = 12,
  parameter int unsigned TIMEOUT = 300,
  parameter int unsigned TO_W    = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_time,
  input  logic       btn_alarm,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic [1:0] cur_H1,
  input  logic [3:0] cur_H0,
  input  logic [3:0] cur_M1,
  input  logic [3:0] cur_M0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic [3:0] edit_field,
  output logic       busy
);

  localparam int unsigned HoldW = $clog2(LD_HOLD + 1);

  logic [3:0]       rise;
  logic [2:0]       state_q, state_d;
  logic             tgt_q, tgt_d;
  logic [1:0]       h1_q, h1_d, sh1_q, sh1_d;
  logic [3:0]       h0_q, h0_d, sh0_q, sh0_d;
  logic [3:0]       m1_q, m1_d, sm1_q, sm1_d;
  logic [3:0]       m0_q, m0_d, sm0_q, sm0_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             ld_time_q, ld_time_d, ld_alarm_q, ld_alarm_d;

  aclock_btn_edge u_btn_edge (
    .clk    (clk),
    .reset  (reset),
    .btn_i  ({btn_time, btn_alarm, btn_next, btn_inc}),
    .rise_o (rise)
  );

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    h1_d       = h1_q;
    h0_d       = h0_q;
    m1_d       = m1_q;
    m0_d       = m0_q;
    sh1_d      = sh1_q;
    sh0_d      = sh0_q;
    sm1_d      = sm1_q;
    sm0_d      = sm0_q;
    to_d       = to_q;
    hold_d     = hold_q;
    ld_time_d  = 1'b0;
    ld_alarm_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        to_d   = '0;
        hold_d = '0;
        if (rise[BtnTime]) begin
          {h1_d, h0_d, m1_d, m0_d} = {cur_H1, cur_H0, cur_M1, cur_M0};
          tgt_d   = 1'b0;
          state_d = StEH1;
        end else if (rise[BtnAlarm]) begin
          {h1_d, h0_d, m1_d, m0_d} = {sh1_q, sh0_q, sm1_q, sm0_q};
          tgt_d   = 1'b1;
          state_d = StEH1;
        end
      end
      StEH1, StEH0, StEM1, StEM0: begin
        to_d = (|rise) ? '0 : to_q + TO_W'(1);
        if (rise[BtnNext]) begin
          unique case (state_q)
            StEH1:   state_d = StEH0;
            StEH0:   state_d = StEM1;
            StEM1:   state_d = StEM0;
            default: begin
              state_d = StLoad;
              hold_d  = '0;
              if (tgt_q) begin
                {sh1_d, sh0_d, sm1_d, sm0_d} = {h1_q, h0_q, m1_q, m0_q};
              end
            end
          endcase
        end else if (rise[BtnInc]) begin
          unique case (state_q)
            StEH1: begin
              h1_d = (h1_q >= H1Max) ? 2'd0 : h1_q + 2'd1;
              // Entering the 20s must not leave an illegal hour such as 25.
              if (h1_d == H1Max && h0_q > H0MaxAt2) h0_d = '0;
            end
            StEH0:   h0_d = digit_inc(h0_q, (h1_q == H1Max) ? H0MaxAt2 : H0Max);
            StEM1:   m1_d = digit_inc(m1_q, M1Max);
            default: m0_d = digit_inc(m0_q, M0Max);
          endcase
        end else if (!(|rise) && to_q == TO_W'(TIMEOUT - 1)) begin
          state_d = StIdle;
          to_d    = '0;
        end
      end
      StLoad: begin
        if (hold_q == HoldW'(LD_HOLD)) begin
          state_d = StIdle;
        end else begin
          hold_d     = hold_q + HoldW'(1);
          ld_time_d  = ~tgt_q;
          ld_alarm_d = tgt_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      tgt_q      <= 1'b0;
      h1_q       <= '0;
      h0_q       <= '0;
      m1_q       <= '0;
      m0_q       <= '0;
      sh1_q      <= '0;
      sh0_q      <= '0;
      sm1_q      <= '0;
      sm0_q      <= '0;
      to_q       <= '0;
      hold_q     <= '0;
      ld_time_q  <= 1'b0;
      ld_alarm_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      h1_q       <= h1_d;
      h0_q       <= h0_d;
      m1_q       <= m1_d;
      m0_q       <= m0_d;
      sh1_q      <= sh1_d;
      sh0_q      <= sh0_d;
      sm1_q      <= sm1_d;
      sm0_q      <= sm0_d;
      to_q       <= to_d;
      hold_q     <= hold_d;
      ld_time_q  <= ld_time_d;
      ld_alarm_q <= ld_alarm_d;
    end
  end

  always_comb begin
    edit_field = '0;
    unique case (state_q)
      StEH1:   edit_field = FieldH1;
      StEH0:   edit_field = FieldH0;
      StEM1:   edit_field = FieldM1;
      StEM0:   edit_field = FieldM0;
      default: edit_field = '0;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign H_in1    = h1_q;
  assign H_in0    = h0_q;
  assign M_in1    = m1_q;
  assign M_in0    = m0_q;
  assign LD_time  = ld_time_q;
  assign LD_alarm = ld_alarm_q;

endmodule

// File: tb/tb_aclock_set_ctrl.sv
// Bench for aclock_set_ctrl: directed scenarios plus random button traffic, all outputs
// compared every cycle against a digit-array model of the setting sequence.
module tb_aclock_set_ctrl;

  localparam int LdHold  = 12;
  localparam int Timeout = 300;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_time = 1'b0, btn_alarm = 1'b0, btn_next = 1'b0, btn_inc = 1'b0;
  logic [1:0] cur_H1 = '0;
  logic [3:0] cur_H0 = '0, cur_M1 = '0, cur_M0 = '0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0, edit_field;
  logic       LD_time, LD_alarm, busy;

  aclock_set_ctrl #(
    .LD_HOLD (12),
    .TIMEOUT (300),
    .TO_W    (9)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_time   (btn_time),
    .btn_alarm  (btn_alarm),
    .btn_next   (btn_next),
    .btn_inc    (btn_inc),
    .cur_H1     (cur_H1),
    .cur_H0     (cur_H0),
    .cur_M1     (cur_M1),
    .cur_M0     (cur_M0),
    .H_in1      (H_in1),
    .H_in0      (H_in0),
    .M_in1      (M_in1),
    .M_in0      (M_in0),
    .LD_time    (LD_time),
    .LD_alarm   (LD_alarm),
    .edit_field (edit_field),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: phase 0 idle, 1..4 editing digit phase-1 (H1,H0,M1,M0), 5 loading.
  int       m_phase = 0;
  int       m_dig[4] = '{0, 0, 0, 0};
  int       m_sh[4]  = '{0, 0, 0, 0};
  bit       m_tgt = 1'b0;
  int       m_idle = 0;
  int       m_age = 0;
  bit [3:0] m_prev = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bump(input int i);
    int lim;
    case (i)
      0:       lim = 2;
      1:       lim = (m_dig[0] == 2) ? 3 : 9;
      2:       lim = 5;
      default: lim = 9;
    endcase
    m_dig[i] = (m_dig[i] + 1) % (lim + 1);
    if (i == 0 && m_dig[0] == 2 && m_dig[1] > 3) m_dig[1] = 0;
  endtask

  task automatic model_step();
    bit [3:0] lv, rise;
    lv = {btn_time, btn_alarm, btn_next, btn_inc};
    if (!reset) begin
      m_phase = 0; m_tgt = 1'b0; m_idle = 0; m_age = 0; m_prev = '0;
      for (int i = 0; i < 4; i++) begin
        m_dig[i] = 0;
        m_sh[i]  = 0;
      end
      return;
    end
    rise   = lv & ~m_prev;
    m_prev = lv;
    if (m_phase == 0) begin
      m_idle = 0;
      if (rise[3]) begin
        m_dig[0] = int'(cur_H1); m_dig[1] = int'(cur_H0);
        m_dig[2] = int'(cur_M1); m_dig[3] = int'(cur_M0);
        m_tgt = 1'b0; m_phase = 1;
      end else if (rise[2]) begin
        for (int i = 0; i < 4; i++) m_dig[i] = m_sh[i];
        m_tgt = 1'b1; m_phase = 1;
      end
    end else if (m_phase <= 4) begin
      if (rise != 0) m_idle = 0;
      if (rise[1]) begin
        m_phase++;
        if (m_phase == 5) begin
          m_age = 0;
          if (m_tgt) for (int i = 0; i < 4; i++) m_sh[i] = m_dig[i];
        end
      end else if (rise[0]) begin
        bump(m_phase - 1);
      end else if (rise == 0) begin
        m_idle++;
        if (m_idle >= Timeout) begin
          m_phase = 0;
          m_idle  = 0;
        end
      end
    end else begin
      m_age++;
      if (m_age > LdHold) m_phase = 0;
    end
  endtask

  // Per-cycle compare of every output against the model.
  initial begin
    bit ld_on;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        ld_on = (m_phase == 5) && (m_age >= 1) && (m_age <= LdHold);
        check("H_in1", 32'(H_in1), 32'(m_dig[0]));
        check("H_in0", 32'(H_in0), 32'(m_dig[1]));
        check("M_in1", 32'(M_in1), 32'(m_dig[2]));
        check("M_in0", 32'(M_in0), 32'(m_dig[3]));
        check("LD_time", 32'(LD_time), 32'(ld_on && !m_tgt));
        check("LD_alarm", 32'(LD_alarm), 32'(ld_on && m_tgt));
        check("edit_field", 32'(edit_field),
              (m_phase >= 1 && m_phase <= 4) ? 32'(8 >> (m_phase - 1)) : 32'd0);
        check("busy", 32'(busy), 32'(m_phase != 0));
      end
    end
  end

  task automatic tick(input logic rst, input logic [3:0] b);
    @(negedge clk);
    reset = rst;
    {btn_time, btn_alarm, btn_next, btn_inc} = b;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    tick(1'b1, b);
    tick(1'b1, 4'b0000);
  endtask

  task automatic set_cur(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                         input logic [3:0] m0);
    cur_H1 = h1; cur_H0 = h0; cur_M1 = m1; cur_M0 = m0;
  endtask

  // Runs n idle cycles and counts how many of them had each load strobe high.
  task automatic run_count(input int n, output int n_t, output int n_a);
    n_t = 0;
    n_a = 0;
    for (int k = 0; k < n; k++) begin
      tick(1'b1, 4'b0000);
      if (LD_time === 1'b1) n_t++;
      if (LD_alarm === 1'b1) n_a++;
    end
  endtask

  initial begin
    int nt, na;
    logic [3:0] lv;
    int unsigned bi;
    set_cur(2'd1, 4'd3, 4'd4, 4'd7);
    tick(1'b0, 4'b0000);
    tick(1'b0, 4'b0000);
    check("reset_outs", 32'({H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, edit_field}), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    chk_en = 1'b1;

    // Time edit from 13:47, H1 -> 2 keeps legal 23, H0 wraps 0..3.
    press(4'b1000);
    check("time_enter_buf", 32'({H_in1, H_in0, M_in1, M_in0}), 32'({2'd1, 4'd3, 4'd4, 4'd7}));
    check("time_enter_field", 32'(edit_field), 32'b1000);
    press(4'b0001);
    check("h1_inc_23", 32'({H_in1, H_in0}), 32'({2'd2, 4'd3}));
    press(4'b0010);
    repeat (4) press(4'b0001);
    check("h0_wrap_23", 32'({H_in1, H_in0}), 32'({2'd2, 4'd3}));
    run_count(310, nt, na);
    check("timeout_idle", 32'(busy), 32'd0);
    check("timeout_no_load", 32'(nt + na), 32'd0);

    // 15:47 -> H1 to 2 forces H0 to 0, then H0 cycles back to 0.
    set_cur(2'd1, 4'd5, 4'd4, 4'd7);
    press(4'b1000);
    press(4'b0001);
    check("h1_force", 32'({H_in1, H_in0, M_in1, M_in0}), 32'({2'd2, 4'd0, 4'd4, 4'd7}));
    press(4'b0010);
    repeat (4) press(4'b0001);
    check("h0_wrap_20", 32'({H_in1, H_in0}), 32'({2'd2, 4'd0}));
    press(4'b0010);
    check("field_m1", 32'(edit_field), 32'b0010);
    press(4'b0011);
    check("next_wins_field", 32'(edit_field), 32'b0001);
    check("next_wins_m1", 32'(M_in1), 32'd4);
    tick(1'b1, 4'b0010);
    run_count(16, nt, na);
    check("time_ld_cycles", 32'(nt), 32'd12);
    check("time_ld_alarm", 32'(na), 32'd0);

    // Alarm edit to 06:30.
    press(4'b0100);
    check("alarm_from_shadow", 32'({H_in1, H_in0, M_in1, M_in0}), 32'd0);
    press(4'b0010);
    repeat (6) press(4'b0001);
    press(4'b0010);
    repeat (3) press(4'b0001);
    press(4'b0010);
    tick(1'b1, 4'b0010);
    run_count(16, nt, na);
    check("alarm_ld_cycles", 32'(na), 32'd12);
    check("alarm_ld_time", 32'(nt), 32'd0);
    check("alarm_busy_after", 32'(busy), 32'd0);
    check("alarm_buf", 32'({H_in1, H_in0, M_in1, M_in0}), 32'({2'd0, 4'd6, 4'd3, 4'd0}));

    // Time and alarm together: time wins, load goes to LD_time.
    set_cur(2'd0, 4'd9, 4'd5, 4'd8);
    press(4'b1100);
    check("both_time_wins", 32'({H_in1, H_in0, M_in1, M_in0}), 32'({2'd0, 4'd9, 4'd5, 4'd8}));
    repeat (3) press(4'b0010);
    tick(1'b1, 4'b0010);
    run_count(16, nt, na);
    check("both_ld_time", 32'(nt), 32'd12);

    // Reset in the fifth cycle of an alarm load.
    press(4'b0100);
    check("alarm_shadow_kept", 32'({H_in1, H_in0, M_in1, M_in0}), 32'({2'd0, 4'd6, 4'd3, 4'd0}));
    repeat (3) press(4'b0010);
    tick(1'b1, 4'b0010);
    repeat (4) tick(1'b1, 4'b0000);
    check("load_mid_ld", 32'(LD_alarm), 32'd1);
    tick(1'b0, 4'b0000);
    check("load_reset_ld", 32'({LD_time, LD_alarm, busy}), 32'd0);
    tick(1'b1, 4'b0000);
    press(4'b0100);
    check("shadow_cleared", 32'({H_in1, H_in0, M_in1, M_in0}), 32'd0);

    // Random button traffic with occasional resets and changing core time.
    lv = '0;
    for (int k = 0; k < 4000; k++) begin
      if (k % 50 == 0) begin
        cur_H1 = 2'($urandom_range(0, 2));
        cur_H0 = 4'($urandom_range(0, (cur_H1 == 2'd2) ? 3 : 9));
        cur_M1 = 4'($urandom_range(0, 5));
        cur_M0 = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 2) == 0) begin
        bi = $urandom_range(0, 3);
        lv[bi[1:0]] = ~lv[bi[1:0]];
      end
      tick(($urandom_range(0, 599) != 0), lv);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
